write_buffer: RTL

- Posted-write FIFO between the last cache level and main memory.
- Write-around stores are queued here and drained to memory in the background.
- Block fetches from a cache miss are serviced from the youngest matching buffered entry when one exists, otherwise forwarded to memory.
- This keeps fetches coherent with writes that have not yet drained.

---
 rtl/write_buffer_if.sv | 37 +++
 rtl/write_buffer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/write_buffer_if.sv
// Cache-side, fetch-side and memory-side signal bundle of the write buffer.
// The buffer connects through the slave modport; the master modport drives it.
interface write_buffer_if #(
  parameter int ADDR_LENGTH = 10,
  parameter int BLOCK_SIZE  = 32,
  parameter int DEPTH       = 4
);
  logic                         wr_en;
  logic [ADDR_LENGTH-1:0]       wr_addr;
  logic [BLOCK_SIZE-1:0]        wr_data;
  logic                         full;
  logic                         wr_drop;
  logic [$clog2(DEPTH):0]       count;
  logic                         rd_en;
  logic [ADDR_LENGTH-1:0]       rd_addr;
  logic [BLOCK_SIZE-1:0]        rd_data;
  logic                         rd_done;
  logic                         rd_busy;
  logic                         mem_enable;
  logic                         mem_write;
  logic [ADDR_LENGTH-1:0]       mem_addr;
  logic [BLOCK_SIZE-1:0]        mem_wdata;
  logic [BLOCK_SIZE-1:0]        mem_rdata;
  logic                         mem_done;

  modport master (
    output wr_en, wr_addr, wr_data, rd_en, rd_addr, mem_rdata, mem_done,
    input  full, wr_drop, count, rd_data, rd_done, rd_busy,
           mem_enable, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_en, rd_addr, mem_rdata, mem_done,
    output full, wr_drop, count, rd_data, rd_done, rd_busy,
           mem_enable, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/write_buffer.sv
// Posted-write FIFO in front of main memory: drains writes in the background and
// serves block fetches from the youngest matching buffered write when present.
module write_buffer #(
  parameter int ADDR_LENGTH      = 10,
  parameter int BLOCK_SIZE       = 32,
  parameter int DEPTH            = 4,
  parameter int BYTE_SELECT_SIZE = $clog2(BLOCK_SIZE/8)
) (
  input  logic          clk,
  input  logic          reset,
  write_buffer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIT   = 2'd1;
  localparam logic [1:0] S_FETCH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [ADDR_LENGTH-1:0] addr_q [DEPTH];
  logic [BLOCK_SIZE-1:0]  data_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   full_q, full_d, wr_drop_q, wr_drop_d;
  logic [1:0]             state_q, state_d;
  logic                   rd_busy_q, rd_busy_d, rd_done_q, rd_done_d;
  logic [ADDR_LENGTH-1:0] pend_addr_q, pend_addr_d;
  logic [BLOCK_SIZE-1:0]  rd_data_q, rd_data_d;
  logic                   mem_enable_q, mem_enable_d, mem_write_q, mem_write_d;
  logic [ADDR_LENGTH-1:0] mem_addr_q, mem_addr_d;
  logic [BLOCK_SIZE-1:0]  mem_wdata_q, mem_wdata_d;
  logic                   push, pop, hit;
  logic [BLOCK_SIZE-1:0]  hit_data;

  // Full is the registered value, so a push on the popping cycle is still dropped.
  assign push = bus.wr_en && !full_q;

  // Walk oldest to youngest so the last valid match is the youngest one.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count_q) &&
          (addr_q[rd_ptr_q + PTR_W'(i)][ADDR_LENGTH-1:BYTE_SELECT_SIZE] ==
           pend_addr_q[ADDR_LENGTH-1:BYTE_SELECT_SIZE])) begin
        hit      = 1'b1;
        hit_data = data_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rd_busy_d    = rd_busy_q;
    rd_done_d    = 1'b0;
    rd_data_d    = rd_data_q;
    pend_addr_d  = pend_addr_q;
    mem_enable_d = mem_enable_q;
    mem_write_d  = mem_write_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    pop          = 1'b0;

    if (bus.rd_en && !rd_busy_q) begin
      rd_busy_d   = 1'b1;
      pend_addr_d = bus.rd_addr;
    end

    case (state_q)
      S_IDLE: begin
        if (rd_busy_q) begin
          if (hit) begin
            state_d   = S_HIT;
            rd_data_d = hit_data;
            rd_done_d = 1'b1;
            rd_busy_d = 1'b0;
          end else begin
            state_d      = S_FETCH;
            mem_enable_d = 1'b1;
            mem_write_d  = 1'b0;
            mem_addr_d   = pend_addr_q;
          end
        end else if (count_q != '0) begin
          state_d      = S_DRAIN;
          mem_enable_d = 1'b1;
          mem_write_d  = 1'b1;
          mem_addr_d   = addr_q[rd_ptr_q];
          mem_wdata_d  = data_q[rd_ptr_q];
        end
      end
      S_HIT: state_d = S_IDLE;
      S_FETCH: begin
        if (bus.mem_done) begin
          state_d      = S_IDLE;
          rd_data_d    = bus.mem_rdata;
          rd_done_d    = 1'b1;
          rd_busy_d    = 1'b0;
          mem_enable_d = 1'b0;
        end
      end
      default: begin
        // Drains always run to completion; a waiting fetch is picked up in IDLE.
        if (bus.mem_done) begin
          state_d      = S_IDLE;
          pop          = 1'b1;
          mem_enable_d = 1'b0;
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
    full_d    = (count_d == CNT_FULL);
    wr_drop_d = bus.wr_en && full_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      wr_drop_q    <= 1'b0;
      rd_busy_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_data_q    <= '0;
      mem_enable_q <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      full_q       <= full_d;
      wr_drop_q    <= wr_drop_d;
      rd_busy_q    <= rd_busy_d;
      rd_done_q    <= rd_done_d;
      rd_data_q    <= rd_data_d;
      mem_enable_q <= mem_enable_d;
      mem_write_q  <= mem_write_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Entry storage and the pending fetch address are qualified by count/rd_busy.
  always_ff @(posedge clk) begin
    pend_addr_q <= pend_addr_d;
    if (push) begin
      addr_q[wr_ptr_q] <= bus.wr_addr;
      data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.full       = full_q;
  assign bus.wr_drop    = wr_drop_q;
  assign bus.count      = count_q;
  assign bus.rd_data    = rd_data_q;
  assign bus.rd_done    = rd_done_q;
  assign bus.rd_busy    = rd_busy_q;
  assign bus.mem_enable = mem_enable_q;
  assign bus.mem_write  = mem_write_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule
